// File: rtl/ysyx_23060240_csr_file.sv
// M-mode CSR file: csrrw/csrrs/csrrc, trap entry / mret state, read-only ID CSRs,
// 64-bit mcycle/minstret and the machine timer interrupt pending output.
module ysyx_23060240_csr_file #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RST_MTVEC = 32'h8000_0000,
   parameter logic [XLEN-1:0] HART_ID   = 32'h0000_0000,
   parameter logic [XLEN-1:0] MISA_VAL  = 32'h4000_0100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc,
   input  logic [11:0]     csr_addr,
   input  logic [1:0]      csr_op,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret,
   input  logic            instret,
   input  logic            irq_timer,
   output logic [XLEN-1:0] trap_target,
   output logic [XLEN-1:0] mret_target,
   output logic            irq_pending
);

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_MINSTR   = 12'hB02;
   localparam logic [11:0] A_MINSTRH  = 12'hB82;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   // only the architecturally live bits are stored; the rest are rebuilt on read
   logic            mst_mie, mst_mpie, mie_mtie;
   logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
   logic [63:0]     mcycle_q, minstret_q;

   logic [XLEN-1:0] mstatus_rd, mip_rd, wval, tvec_base;
   logic            hit, ro, wr_req, blocked, wr_en;

   // Rebuild WARL views of mstatus and mip from their stored bits
   always_comb begin
      mstatus_rd        = '0;
      mstatus_rd[12:11] = 2'b11;
      mstatus_rd[7]     = mst_mpie;
      mstatus_rd[3]     = mst_mie;
      mip_rd            = '0;
      mip_rd[7]         = irq_timer;
   end

   // Old-value read mux; also classifies the address as implemented / read-only
   always_comb begin
      csr_rdata = '0;
      hit       = 1'b1;
      ro        = 1'b0;
      case (csr_addr)
         A_MSTATUS:  csr_rdata = mstatus_rd;
         A_MISA:     begin csr_rdata = MISA_VAL; ro = 1'b1; end
         A_MIE:      csr_rdata[7] = mie_mtie;
         A_MTVEC:    csr_rdata = mtvec_q;
         A_MSCRATCH: csr_rdata = mscratch_q;
         A_MEPC:     csr_rdata = mepc_q;
         A_MCAUSE:   csr_rdata = mcause_q;
         A_MTVAL:    csr_rdata = mtval_q;
         A_MIP:      begin csr_rdata = mip_rd; ro = 1'b1; end
         A_MCYCLE:   csr_rdata = mcycle_q[31:0];
         A_MCYCLEH:  csr_rdata = mcycle_q[63:32];
         A_MINSTR:   csr_rdata = minstret_q[31:0];
         A_MINSTRH:  csr_rdata = minstret_q[63:32];
         A_MHARTID:  begin csr_rdata = HART_ID; ro = 1'b1; end
         default:    hit = 1'b0;
      endcase
   end

   // New value for the addressed CSR from the op and its old value
   always_comb begin
      case (csr_op)
         OP_RW:   wval = csr_wdata;
         OP_RS:   wval = csr_rdata | csr_wdata;
         OP_RC:   wval = csr_rdata & ~csr_wdata;
         default: wval = csr_rdata;
      endcase
   end

   // set/clear with a zero mask is a pure read; trap/mret swallow the write entirely
   assign wr_req      = (csr_op == OP_RW) || ((csr_op != OP_NONE) && (csr_wdata != '0));
   assign blocked     = trap_valid | mret;
   assign wr_en       = wr_req & hit & ~ro & ~blocked;
   assign csr_illegal = wr_req & ~blocked & (~hit | ro);

   assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
   assign trap_target = (mtvec_q[0] && trap_cause[XLEN-1])
                        ? tvec_base + {trap_cause[XLEN-3:0], 2'b00} : tvec_base;
   assign mret_target = mepc_q;
   assign irq_pending = mst_mie & mie_mtie & irq_timer;

   // Trap/mret state and software writes, in that priority order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mst_mie    <= 1'b0;
         mst_mpie   <= 1'b0;
         mie_mtie   <= 1'b0;
         mtvec_q    <= RST_MTVEC & ~XLEN'(2);
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mscratch_q <= '0;
      end else if (trap_valid) begin
         mepc_q   <= pc & ~XLEN'(3);
         mcause_q <= trap_cause;
         mtval_q  <= trap_tval;
         mst_mpie <= mst_mie;
         mst_mie  <= 1'b0;
      end else if (mret) begin
         mst_mie  <= mst_mpie;
         mst_mpie <= 1'b1;
      end else if (wr_en) begin
         case (csr_addr)
            A_MSTATUS:  begin mst_mie <= wval[3]; mst_mpie <= wval[7]; end
            A_MIE:      mie_mtie   <= wval[7];
            A_MTVEC:    mtvec_q    <= wval & ~XLEN'(2);
            A_MSCRATCH: mscratch_q <= wval;
            A_MEPC:     mepc_q     <= wval & ~XLEN'(3);
            A_MCAUSE:   mcause_q   <= wval;
            A_MTVAL:    mtval_q    <= wval;
            default:    ;
         endcase
      end
   end

   // A written half takes the new value; a written lo half also eats the carry
   function automatic logic [63:0] cnt_next(input logic [63:0] cur, input logic inc,
                                            input logic wr_lo, input logic wr_hi,
                                            input logic [31:0] nv);
      logic [32:0] lo_sum;
      logic [31:0] lo, hi;
      lo_sum = {1'b0, cur[31:0]} + {32'd0, inc};
      lo     = wr_lo ? nv : lo_sum[31:0];
      hi     = wr_hi ? nv : cur[63:32] + {31'd0, lo_sum[32] & ~wr_lo};
      return {hi, lo};
   endfunction

   // 64-bit cycle and retired-instruction counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= cnt_next(mcycle_q, 1'b1,
                                wr_en && (csr_addr == A_MCYCLE),
                                wr_en && (csr_addr == A_MCYCLEH), wval);
         minstret_q <= cnt_next(minstret_q, instret,
                                wr_en && (csr_addr == A_MINSTR),
                                wr_en && (csr_addr == A_MINSTRH), wval);
      end
   end

endmodule

// File: tb/tb_ysyx_23060240_csr_file.sv
// Directed bench for the M-mode CSR file; all expected values are hand-derived constants.
module tb_ysyx_23060240_csr_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc, csr_wdata, csr_rdata, trap_cause, trap_tval, trap_target, mret_target;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic        csr_illegal, trap_valid, mret, instret, irq_timer, irq_pending;

   int n_cmp = 0;
   int n_err = 0;

   ysyx_23060240_csr_file #(
      .XLEN(32), .RST_MTVEC(32'h8000_0000), .HART_ID(32'h0000_0003), .MISA_VAL(32'h4000_0100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .csr_addr(csr_addr), .csr_op(csr_op),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_tval(trap_tval), .mret(mret),
      .instret(instret), .irq_timer(irq_timer), .trap_target(trap_target),
      .mret_target(mret_target), .irq_pending(irq_pending)
   );

   always #5 clk = ~clk;

   // watchdog: the sequence is fixed-length, this only guards against a stuck run
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h want %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
      csr_op   = 2'b00;
      csr_addr = a;
      #1;
      chk(tag, csr_rdata, exp);
   endtask

   task automatic cwr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      csr_op    = op;
      csr_addr  = a;
      csr_wdata = d;
      tick();
      csr_op    = 2'b00;
      csr_wdata = '0;
   endtask

   initial begin
      rst_n = 1'b0; pc = '0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
      trap_valid = 1'b0; trap_cause = '0; trap_tval = '0; mret = 1'b0;
      instret = 1'b0; irq_timer = 1'b0;
      tick(); tick();

      // reset state
      rd(12'h300, 32'h0000_1800, "rst_mstatus");
      rd(12'h305, 32'h8000_0000, "rst_mtvec");
      rd(12'hF14, 32'h0000_0003, "rst_mhartid");
      rd(12'h341, 32'h0000_0000, "rst_mepc");
      rd(12'hB00, 32'h0000_0000, "rst_mcycle");
      chk("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
      rst_n = 1'b1;
      tick();
      rd(12'hB00, 32'h0000_0001, "mcycle_1");
      tick();
      rd(12'hB00, 32'h0000_0002, "mcycle_2");
      rd(12'h301, 32'h4000_0100, "misa");

      // RW / RS / RC on mscratch
      cwr(2'b01, 12'h340, 32'hA5A5_0000);
      rd(12'h340, 32'hA5A5_0000, "scratch_rw");
      cwr(2'b10, 12'h340, 32'h0000_00FF);
      rd(12'h340, 32'hA5A5_00FF, "scratch_rs");
      cwr(2'b11, 12'h340, 32'hA000_0000);
      rd(12'h340, 32'h05A5_00FF, "scratch_rc");
      csr_op = 2'b10; csr_addr = 12'h340; csr_wdata = '0; #1;
      chk("rs0_illegal", {31'd0, csr_illegal}, 32'd0);
      tick(); csr_op = 2'b00;
      rd(12'h340, 32'h05A5_00FF, "rs0_nochange");
      csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 32'h1; #1;
      chk("unimpl_illegal", {31'd0, csr_illegal}, 32'd1);
      chk("unimpl_rdata", csr_rdata, 32'd0);
      csr_op = 2'b11; csr_wdata = '0; #1;
      chk("unimpl_rc0_illegal", {31'd0, csr_illegal}, 32'd0);
      csr_op = 2'b00;

      // trap entry then mret
      cwr(2'b01, 12'h300, 32'hFFFF_FF77);
      rd(12'h300, 32'h0000_1800, "mstatus_warl_clear");
      cwr(2'b01, 12'h300, 32'h0000_0008);
      rd(12'h300, 32'h0000_1808, "mstatus_mie");
      trap_valid = 1'b1; pc = 32'h8000_0102; trap_cause = 32'h0000_000B; trap_tval = 32'h1234;
      #1;
      chk("trap_target_direct", trap_target, 32'h8000_0000);
      tick(); trap_valid = 1'b0;
      rd(12'h341, 32'h8000_0100, "trap_mepc");
      rd(12'h342, 32'h0000_000B, "trap_mcause");
      rd(12'h343, 32'h0000_1234, "trap_mtval");
      rd(12'h300, 32'h0000_1880, "trap_mstatus");
      chk("mret_target", mret_target, 32'h8000_0100);
      mret = 1'b1; csr_op = 2'b01; csr_addr = 12'hF14; csr_wdata = 32'h9; #1;
      chk("mret_ro_not_illegal", {31'd0, csr_illegal}, 32'd0);
      csr_addr = 12'h340;
      tick(); mret = 1'b0; csr_op = 2'b00;
      rd(12'h300, 32'h0000_1888, "mret_mstatus");
      rd(12'h340, 32'h05A5_00FF, "mret_blocks_write");

      // vectored trap beats a same-cycle mepc write
      cwr(2'b01, 12'h305, 32'h8000_0003);
      rd(12'h305, 32'h8000_0001, "mtvec_bit1");
      trap_valid = 1'b1; pc = 32'h8000_0204; trap_cause = 32'h8000_0007; trap_tval = '0;
      csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'hDEAD_BEEF; #1;
      chk("trap_target_vec", trap_target, 32'h8000_001C);
      chk("trap_write_not_illegal", {31'd0, csr_illegal}, 32'd0);
      trap_cause = 32'h0000_0002; #1;
      chk("trap_target_vec_sync", trap_target, 32'h8000_0000);
      trap_cause = 32'h8000_0007;
      tick(); trap_valid = 1'b0; csr_op = 2'b00;
      rd(12'h341, 32'h8000_0204, "trap_beats_write");
      rd(12'h342, 32'h8000_0007, "irq_mcause");
      rd(12'h300, 32'h0000_1880, "trap2_mstatus");
      cwr(2'b01, 12'h341, 32'h1234_5677);
      rd(12'h341, 32'h1234_5674, "mepc_align");

      // counters: carry lo->hi, read-only writes
      cwr(2'b01, 12'hB80, 32'h0000_0000);
      cwr(2'b01, 12'hB00, 32'hFFFF_FFFF);
      rd(12'hB00, 32'hFFFF_FFFF, "mcycle_lo_written");
      rd(12'hB80, 32'h0000_0000, "mcycle_hi_nocarry");
      tick();
      rd(12'hB00, 32'h0000_0000, "mcycle_wrap_lo");
      rd(12'hB80, 32'h0000_0001, "mcycle_wrap_hi");
      cwr(2'b01, 12'hB02, 32'h0000_0010);
      rd(12'hB02, 32'h0000_0010, "minstret_written");
      tick();
      rd(12'hB02, 32'h0000_0010, "minstret_idle");
      instret = 1'b1; tick(); tick(); tick(); instret = 1'b0;
      rd(12'hB02, 32'h0000_0013, "minstret_count");
      cwr(2'b01, 12'hB82, 32'h0000_0042);
      rd(12'hB82, 32'h0000_0042, "minstret_hi");
      csr_op = 2'b01; csr_addr = 12'hF14; csr_wdata = 32'h55; #1;
      chk("hartid_illegal", {31'd0, csr_illegal}, 32'd1);
      tick(); csr_op = 2'b00;
      rd(12'hF14, 32'h0000_0003, "hartid_nochange");

      // timer interrupt pending
      cwr(2'b01, 12'h304, 32'hFFFF_FFFF);
      rd(12'h304, 32'h0000_0080, "mie_warl");
      cwr(2'b10, 12'h300, 32'h0000_0008);
      irq_timer = 1'b1; #1;
      chk("irq_pending_on", {31'd0, irq_pending}, 32'd1);
      rd(12'h344, 32'h0000_0080, "mip_mtip");
      cwr(2'b11, 12'h300, 32'h0000_0008);
      chk("irq_pending_off", {31'd0, irq_pending}, 32'd0);
      irq_timer = 1'b0;
      rd(12'h344, 32'h0000_0000, "mip_clear");

      // async reset in the middle of a pending write
      csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h77; #1;
      rst_n = 1'b0; #1;
      chk("midrst_scratch", csr_rdata, 32'h0000_0000);
      rd(12'h300, 32'h0000_1800, "midrst_mstatus");
      rd(12'h305, 32'h8000_0000, "midrst_mtvec");
      tick();
      rst_n = 1'b1;
      rd(12'h340, 32'h0000_0000, "postrst_scratch");
      rd(12'hB80, 32'h0000_0000, "postrst_mcycleh");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
